// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and sizing helpers for the digit-serial adder controller.
package serial_add_pkg;

  // Default operand/sum width.
  localparam int DEFAULT_WIDTH = 8;

  // Number of bits the slice consumes per cycle.
  localparam int DIGIT_BITS = 2;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slice passes needed for a given width.
  function automatic int calc_n(input int width);
    return width / DIGIT_BITS;
  endfunction

  // Pass-counter width. Never less than one bit, so WIDTH=2 still has a counter.
  function automatic int calc_cnt_w(input int width);
    int n;
    n = width / DIGIT_BITS;
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the digit-serial adder controller.
interface serial_adder_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;

  // Operand source / result consumer side.
  modport master (
    output start_valid, a, b, c_in, done_ready,
    input  start_ready, done_valid, sum, c_out, busy
  );

  // Adder controller side.
  modport slave (
    input  start_valid, a, b, c_in, done_ready,
    output start_ready, done_valid, sum, c_out, busy
  );

endinterface

// File: rtl/serial_adder_ctrl_slice.sv
// Combinational 2-bit full adder; the only arithmetic in the serial adder.
module adder2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic [2:0] total_s;

  // Add the two digits and the incoming carry at three-bit precision.
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {2'b00, cin};
  end

  assign s    = total_s[1:0];
  assign cout = total_s[2];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Digit-serial WIDTH-bit adder: one 2-bit slice reused low digit to high,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus
);

  localparam int N       = calc_n(WIDTH);
  localparam int CNT_W   = calc_cnt_w(WIDTH);
  localparam int SUM_TOP = WIDTH - DIGIT_BITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t            state_r;
  state_t            state_s;
  logic [WIDTH-1:0]  a_sh_r;
  logic [WIDTH-1:0]  b_sh_r;
  logic [WIDTH-1:0]  sum_sh_r;
  logic              carry_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [WIDTH-1:0]  sum_r;
  logic              c_out_r;

  logic [1:0]        slice_s;
  logic              slice_cout_s;
  logic [WIDTH-1:0]  sum_sh_next_s;
  logic              accept_s;
  logic              last_pass_s;

  adder2_slice u_slice (
    .a    (a_sh_r[1:0]),
    .b    (b_sh_r[1:0]),
    .cin  (carry_r),
    .s    (slice_s),
    .cout (slice_cout_s)
  );

  // Handshake qualifiers and the next partial-sum image (new digit enters at the top).
  always_comb begin
    accept_s      = (state_r == IDLE) && bus.start_valid;
    last_pass_s   = (state_r == BUSY) && (cnt_r == CNT_LAST);
    sum_sh_next_s = (sum_sh_r >> 2'd2) | (WIDTH'(slice_s) << SUM_TOP);
  end

  // Next-state decode: accept in IDLE, N passes in BUSY, hold result until taken.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start_valid) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (bus.done_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand shifters, carry and pass counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            carry_r <= bus.c_in;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        BUSY: begin
          a_sh_r   <= a_sh_r >> 2'd2;
          b_sh_r   <= b_sh_r >> 2'd2;
          sum_sh_r <= sum_sh_next_s;
          carry_r  <= slice_cout_s;
          cnt_r    <= cnt_r + CNT_ONE;
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Result registers: updated only on the final pass so they stay stable in DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r   <= '0;
      c_out_r <= 1'b0;
    end else if (last_pass_s) begin
      sum_r   <= sum_sh_next_s;
      c_out_r <= slice_cout_s;
    end else begin
      sum_r   <= sum_r;
      c_out_r <= c_out_r;
    end
  end

  // Outputs come only from registered state.
  assign bus.start_ready = (state_r == IDLE);
  assign bus.done_valid  = (state_r == DONE);
  assign bus.busy        = (state_r == BUSY);
  assign bus.sum         = sum_r;
  assign bus.c_out       = c_out_r;

endmodule
